serial_right_shifter: RTL



---
 rtl/serial_right_shifter_if.sv | 36 +++
 rtl/serial_right_shifter.sv | 94 +++++++++
 2 files changed

// File: rtl/serial_right_shifter_if.sv
// rtl/serial_right_shifter_if.sv - issue/result bus between control unit and serial right shifter
//
// Purpose: groups the start/operand request and busy/done/result response of
// the serial right shifter into one bundle.
// Signals:
//   start    request pulse/level, sampled by the shifter only when idle
//   arith    1 = SRA (sign fill), 0 = SRL (zero fill)
//   shamt    unsigned shift amount
//   data_in  operand
//   busy     high while an operation is in flight
//   done     one-cycle result-valid pulse
//   data_out result, held until the next accepted start
// Modports: master = control unit side, slave = shifter side.

interface serial_right_shifter_if #(
    parameter int N_BITS     = 32,
    parameter int SHAMT_BITS = 5
);
    logic                  start;
    logic                  arith;
    logic [SHAMT_BITS-1:0] shamt;
    logic [N_BITS-1:0]     data_in;
    logic                  busy;
    logic                  done;
    logic [N_BITS-1:0]     data_out;

    modport master (
        output start, arith, shamt, data_in,
        input  busy, done, data_out
    );

    modport slave (
        input  start, arith, shamt, data_in,
        output busy, done, data_out
    );
endinterface

// File: rtl/serial_right_shifter.sv
// rtl/serial_right_shifter.sv - multi-cycle SRL/SRA unit, one bit position per clock
//
// Purpose: right-shifts an operand by shamt positions, one position per rising
// edge, filling with zero (SRL) or the operand sign bit (SRA).
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  asynchronous active-high reset, aborts any operation in flight
//   bus    slave side of serial_right_shifter_if (start/arith/shamt/data_in
//          in, busy/done/data_out out)

module serial_right_shifter #(
    parameter int N_BITS     = 32,
    parameter int SHAMT_BITS = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_right_shifter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q;
    logic [N_BITS-1:0]     shift_reg_q;
    logic [SHAMT_BITS-1:0] count_q;
    logic                  fill_bit_q;
    logic                  busy_q;
    logic                  done_q;

    logic [N_BITS-1:0]     shift_reg_d;
    logic [SHAMT_BITS-1:0] count_d;

    // One position of right shift per edge; fill_bit is already zero for SRL.
    assign shift_reg_d = {fill_bit_q, shift_reg_q[N_BITS-1:1]};
    assign count_d     = count_q - SHAMT_BITS'(1);

    // busy/done are registered alongside the state so they depend on state only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_reg_q <= '0;
            count_q     <= '0;
            fill_bit_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        shift_reg_q <= bus.data_in;
                        count_q     <= bus.shamt;
                        fill_bit_q  <= bus.arith & bus.data_in[N_BITS-1];
                        busy_q      <= 1'b1;
                        if (bus.shamt != '0) begin
                            state_q <= SHIFT;
                            done_q  <= 1'b0;
                        end else begin
                            // Zero shift: result is the operand, report next cycle.
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    shift_reg_q <= shift_reg_d;
                    count_q     <= count_d;
                    if (count_q == SHAMT_BITS'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    // start is ignored here; the earliest re-accept is the next IDLE edge.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.data_out = shift_reg_q;

endmodule
